// File: rtl/bist_session_sched_if.sv
// bist_session_sched_if: request/datapath-control bundle for the BIST session scheduler.
// abort/aborted exist only when BIST_ABORT_EN is defined.
interface bist_session_sched_if #(
  parameter int N_CUT = 4,
  parameter int SEL_W = 2
);
  logic             start;
  logic [N_CUT-1:0] cut_mask;
  logic             sig_match;
  logic [SEL_W-1:0] cut_sel;
  logic             init;
  logic             running;
  logic             toggle;
  logic             finish;
  logic             busy;
  logic [N_CUT-1:0] pass_vec;
  logic             bist_end;
`ifdef BIST_ABORT_EN
  logic             abort;
  logic             aborted;
  modport master (output start, cut_mask, sig_match, abort,
                  input cut_sel, init, running, toggle, finish, busy, pass_vec, bist_end, aborted);
  modport slave  (input start, cut_mask, sig_match, abort,
                  output cut_sel, init, running, toggle, finish, busy, pass_vec, bist_end, aborted);
`else
  modport master (output start, cut_mask, sig_match,
                  input cut_sel, init, running, toggle, finish, busy, pass_vec, bist_end);
  modport slave  (input start, cut_mask, sig_match,
                  output cut_sel, init, running, toggle, finish, busy, pass_vec, bist_end);
`endif
endinterface

// File: rtl/bist_session_sched.sv
// bist_session_sched: sequences BIST sessions over the enabled CUTs sharing one LFSR/MISR datapath.
// Optional BIST_ABORT_EN adds an abort input and a sticky aborted flag.
module bist_session_sched #(
  parameter int N_CUT         = 4,
  parameter int SEL_W         = 2,
  parameter int NCLOCK        = 650,
  parameter int TOGGLE_PERIOD = 10
) (
  input logic clk,
  input logic reset,
  bist_session_sched_if.slave bus
);
  localparam int CW = $clog2(NCLOCK + 1);
  localparam int TW = $clog2(TOGGLE_PERIOD + 1);
  localparam logic [CW-1:0] NC = CW'(NCLOCK);
  localparam logic [TW-1:0] TP = TW'(TOGGLE_PERIOD);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_CHECK, S_END} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [N_CUT-1:0] mask_q, mask_n, pass_n;
  logic [SEL_W-1:0] sel_n, nxt;
  logic hit;
`ifdef BIST_ABORT_EN
  logic ab_n;
`endif

  // In IDLE search the live mask from bit 0; otherwise the latched mask strictly above cut_sel.
  always_comb begin
    hit = 1'b0;
    nxt = bus.cut_sel;
    for (int i = N_CUT - 1; i >= 0; i--)
      if (state == S_IDLE ? bus.cut_mask[i] : (mask_q[i] && i > int'(bus.cut_sel))) begin
        hit = 1'b1;
        nxt = SEL_W'(i);
      end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tcnt_n  = tcnt;
    mask_n  = mask_q;
    pass_n  = bus.pass_vec;
    sel_n   = bus.cut_sel;
`ifdef BIST_ABORT_EN
    ab_n    = bus.aborted;
`endif
    case (state)
      S_IDLE: if (bus.start) begin
        state_n = hit ? S_INIT : S_END;
        sel_n   = hit ? nxt : bus.cut_sel;
        mask_n  = bus.cut_mask;
        pass_n  = '0;
`ifdef BIST_ABORT_EN
        ab_n    = 1'b0;
`endif
      end
      S_INIT: begin
        state_n = S_RUN;
        cnt_n   = CW'(1);
        tcnt_n  = TW'(1);
      end
      S_RUN: begin
        state_n = cnt == NC ? S_CHECK : S_RUN;
        cnt_n   = cnt == NC ? cnt : cnt + 1'b1;
        tcnt_n  = tcnt == TP ? TW'(1) : tcnt + 1'b1;
      end
      S_CHECK: begin
        pass_n[bus.cut_sel] = bus.sig_match;
        state_n = hit ? S_INIT : S_END;
        sel_n   = hit ? nxt : bus.cut_sel;
      end
      default: state_n = S_IDLE;
    endcase
`ifdef BIST_ABORT_EN
    if (bus.abort && (state == S_INIT || state == S_RUN || state == S_CHECK)) begin
      state_n = S_END;
      pass_n  = bus.pass_vec;
      sel_n   = bus.cut_sel;
      ab_n    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tcnt         <= '0;
      mask_q       <= '0;
      bus.cut_sel  <= '0;
      bus.pass_vec <= '0;
      bus.init     <= 1'b0;
      bus.running  <= 1'b0;
      bus.toggle   <= 1'b0;
      bus.finish   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.bist_end <= 1'b0;
`ifdef BIST_ABORT_EN
      bus.aborted  <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      tcnt         <= tcnt_n;
      mask_q       <= mask_n;
      bus.cut_sel  <= sel_n;
      bus.pass_vec <= pass_n;
      bus.init     <= state_n == S_INIT;
      bus.running  <= state_n == S_RUN;
      bus.toggle   <= state_n == S_RUN && tcnt_n == TP;
      bus.finish   <= state_n == S_CHECK;
      bus.busy     <= state_n != S_IDLE;
      bus.bist_end <= state_n == S_END;
`ifdef BIST_ABORT_EN
      bus.aborted  <= ab_n;
`endif
    end
  end
endmodule
